alu_slave_gen2: RTL and testbench

ALU_SLAVE_GEN2 -- requirements
Module: alu_slave_gen2

---
 rtl/alu_slave_gen2.sv | 128 ++++++++++++
 tb/tb_alu_slave_gen2.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_slave_gen2.sv
// Memory-mapped slave front-end for an ALU: control/status registers, instruction push,
// result pop and a register-file window. Registered read data; combinational FIFO/RF strobes.
module alu_slave_gen2 #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [15:0]       s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              s_interrupt,
  input  logic [1:0]        status,
  input  logic              op_done,
  input  logic              op_fault,
  input  logic              inst_full,
  output logic              wr_en_inst,
  output logic [DATA_W-1:0] inst,
  input  logic              result_empty,
  input  logic [DATA_W-1:0] result,
  output logic              result_pop,
  output logic              op_start,
  output logic              we_rf,
  output logic [RF_AW-1:0]  wAddr,
  output logic [DATA_W-1:0] wData,
  output logic [RF_AW-1:0]  rAddr,
  input  logic [DATA_W-1:0] rData
);

  localparam int SW = DATA_W + CNT_W + 2;
  localparam logic [8:0] RF_END = 9'h010 + (9'd1 << RF_AW);

  logic              wr, rd, in_rf;
  logic [7:0]        a;
  logic              op_start_r;
  logic [2:0]        int_pend, int_en, pend_set, pend_clr;
  logic [DATA_W-1:0] instruction_r;
  logic [CNT_W-1:0]  inst_cnt;
  logic              inst_wr, accept, err;
  logic [DATA_W-1:0] rd_data;
  logic [SW-1:0]     status_wide, cnt_wide;
  logic              unused_addr_hi;

  assign unused_addr_hi = &{1'b0, s_addr[15:8]};

  assign a     = s_addr[7:0];
  assign wr    = s_sel & s_wr;
  assign rd    = s_sel & ~s_wr;
  assign in_rf = (a >= 8'h10) && ({1'b0, a} < RF_END);

  assign inst_wr    = wr && (a == 8'h03);
  assign accept     = inst_wr && (status == 2'b00) && !inst_full;
  assign wr_en_inst = accept;
  assign inst       = accept ? s_din : '0;

  assign result_pop = rd && (a == 8'h04) && !result_empty;
  // Rejected pushes and pops of an empty result FIFO share one error flag.
  assign err        = (inst_wr && !accept) || (rd && (a == 8'h04) && result_empty);

  assign we_rf = wr && in_rf;
  assign wAddr = we_rf ? a[RF_AW-1:0] : '0;
  assign wData = we_rf ? s_din : '0;
  assign rAddr = (rd && in_rf) ? a[RF_AW-1:0] : '0;

  assign op_start = op_start_r;

  assign pend_set = {err, op_fault, op_done};
  assign pend_clr = (wr && (a == 8'h01)) ? s_din[2:0] : 3'b000;

  assign status_wide = {{DATA_W{1'b0}}, inst_cnt, status};
  assign cnt_wide    = {{(DATA_W + 2){1'b0}}, inst_cnt};

  always_comb begin
    rd_data = '0;
    if (in_rf) begin
      rd_data = rData;
    end else begin
      case (a)
        8'h00:   rd_data = {{(DATA_W-1){1'b0}}, op_start_r};
        8'h01:   rd_data = {{(DATA_W-3){1'b0}}, int_pend};
        8'h02:   rd_data = {{(DATA_W-3){1'b0}}, int_en};
        8'h03:   rd_data = instruction_r;
        8'h04:   rd_data = result_empty ? '0 : result;
        8'h05:   rd_data = status_wide[DATA_W-1:0];
        8'h06:   rd_data = cnt_wide[DATA_W-1:0];
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_start_r    <= 1'b0;
      int_pend      <= 3'b000;
      int_en        <= 3'b000;
      instruction_r <= '0;
      inst_cnt      <= '0;
      s_dout        <= '0;
      s_interrupt   <= 1'b0;
    end else begin
      // A write to OP_START takes priority over the completion pulses.
      if (wr && (a == 8'h00))
        op_start_r <= s_din[0];
      else if (op_done || op_fault)
        op_start_r <= 1'b0;

      int_pend <= (int_pend & ~pend_clr) | pend_set;

      if (wr && (a == 8'h02))
        int_en <= s_din[2:0];

      if (accept)
        instruction_r <= s_din;

      if (wr && (a == 8'h06))
        inst_cnt <= '0;
      else if (accept)
        inst_cnt <= inst_cnt + CNT_W'(1);

      s_dout      <= rd ? rd_data : '0;
      s_interrupt <= |(int_pend & int_en);
    end
  end

endmodule

// File: tb/tb_alu_slave_gen2.sv
// Randomised bench for alu_slave_gen2: a register-map model predicts every cycle, a monitor
// compares registered outputs from a queue while the driver checks combinational strobes.
module tb_alu_slave_gen2;

  localparam int DW = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_sel = 1'b0, s_wr = 1'b0;
  logic [15:0]   s_addr = '0;
  logic [DW-1:0] s_din = '0;
  logic [DW-1:0] s_dout;
  logic          s_interrupt;
  logic [1:0]    status = 2'b00;
  logic          op_done = 1'b0, op_fault = 1'b0, inst_full = 1'b0;
  logic          wr_en_inst;
  logic [DW-1:0] inst;
  logic          result_empty = 1'b1;
  logic [DW-1:0] result = '0;
  logic          result_pop, op_start, we_rf;
  logic [AW-1:0] wAddr, rAddr;
  logic [DW-1:0] wData;
  logic [DW-1:0] rData = '0;

  alu_slave_gen2 #(.DATA_W(DW), .RF_AW(AW), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din),
    .s_dout(s_dout), .s_interrupt(s_interrupt), .status(status), .op_done(op_done),
    .op_fault(op_fault), .inst_full(inst_full), .wr_en_inst(wr_en_inst), .inst(inst),
    .result_empty(result_empty), .result(result), .result_pop(result_pop),
    .op_start(op_start), .we_rf(we_rf), .wAddr(wAddr), .wData(wData), .rAddr(rAddr),
    .rData(rData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dout;
    logic          intr;
    logic          op;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Architectural state of the register map as seen by software.
  logic          m_op = 1'b0;
  logic [2:0]    m_pend = 3'b0, m_en = 3'b0;
  logic [DW-1:0] m_inst = '0;
  int            m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic sel, input logic wr, input logic [15:0] addr,
                       input logic [DW-1:0] din, input logic [1:0] st, input logic done,
                       input logic fault, input logic full, input logic rempty,
                       input logic [DW-1:0] res, input logic [DW-1:0] rdat);
    logic [7:0]    a;
    logic          w, r, in_rf, e_push, e_pop, e_we, err;
    logic [DW-1:0] rv;
    exp_t          e;
    @(negedge clk);
    reset = rst; s_sel = sel; s_wr = wr; s_addr = addr; s_din = din; status = st;
    op_done = done; op_fault = fault; inst_full = full; result_empty = rempty;
    result = res; rData = rdat;
    #1;
    a = addr[7:0];
    w = sel && wr;
    r = sel && !wr;
    in_rf = (a >= 8'h10) && (a < 8'h18);
    e_push = w && a == 8'h03 && st == 2'b00 && !full;
    e_pop  = r && a == 8'h04 && !rempty;
    e_we   = w && in_rf;
    chk("wr_en_inst", wr_en_inst, e_push);
    chk("inst", inst, e_push ? din : 0);
    chk("result_pop", result_pop, e_pop);
    chk("we_rf", we_rf, e_we);
    chk("wAddr", wAddr, e_we ? a - 8'h10 : 0);
    chk("wData", wData, e_we ? din : 0);
    chk("rAddr", rAddr, (r && in_rf) ? a - 8'h10 : 0);

    rv = '0;
    if (r) begin
      if (in_rf) rv = rdat;
      else case (a)
        8'h00: rv = DW'(m_op);
        8'h01: rv = DW'(m_pend);
        8'h02: rv = DW'(m_en);
        8'h03: rv = m_inst;
        8'h04: rv = rempty ? '0 : res;
        8'h05: rv = DW'(m_cnt * 4 + st);
        8'h06: rv = DW'(m_cnt);
        default: rv = '0;
      endcase
    end

    if (rst) begin
      m_op = 0; m_pend = 0; m_en = 0; m_inst = 0; m_cnt = 0;
      e.dout = 0; e.intr = 0;
    end else begin
      e.dout = rv;
      e.intr = |(m_pend & m_en);
      err = (w && a == 8'h03 && !e_push) || (r && a == 8'h04 && rempty);
      if (w && a == 8'h00) m_op = din[0];
      else if (done || fault) m_op = 0;
      if (w && a == 8'h01) m_pend = m_pend & ~din[2:0];
      m_pend = m_pend | {err, fault, done};
      if (w && a == 8'h02) m_en = din[2:0];
      if (e_push) m_inst = din;
      if (w && a == 8'h06) m_cnt = 0;
      else if (e_push) m_cnt = (m_cnt + 1) % 4;
    end
    e.op = m_op;
    q.push_back(e);
  endtask

  task automatic bus(input logic wr, input logic [7:0] a, input logic [DW-1:0] din);
    drive(0, 1, wr, {8'h00, a}, din, 2'b00, 0, 0, 0, 1, 32'h0, 32'h0);
  endtask

  task automatic idle(input logic done, input logic fault);
    drive(0, 0, 0, 16'h0, 32'h0, 2'b00, done, fault, 0, 1, 32'h0, 32'h0);
  endtask

  // Registered outputs are compared just after each edge against the queued prediction.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("s_dout", s_dout, e.dout);
        chk("s_interrupt", s_interrupt, e.intr);
        chk("op_start", op_start, e.op);
      end
    end
  end

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 1, 1, 16'h0000, 32'h1, 0, 1, 0, 0, 1, 0, 0);
    idle(0, 0);

    // Enable all interrupts, push one instruction, read the counter.
    bus(1, 8'h02, 32'h7);
    bus(1, 8'h03, 32'hA5);
    bus(0, 8'h06, 32'h0);
    bus(0, 8'h03, 32'h0);

    // Start, finish, interrupt, acknowledge.
    bus(1, 8'h00, 32'h1);
    idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    bus(0, 8'h01, 32'h0);
    bus(1, 8'h01, 32'h1);
    idle(0, 0);
    idle(0, 0);

    // Rejected push and empty pop.
    drive(0, 1, 1, 16'h0003, 32'h55, 2'b00, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 16'h0003, 32'h66, 2'b10, 0, 0, 0, 1, 0, 0);
    drive(0, 1, 0, 16'h0004, 32'h0, 2'b00, 0, 0, 0, 1, 32'hBAD, 0);
    bus(0, 8'h01, 32'h0);
    bus(0, 8'h05, 32'h0);

    // Register-file window, its upper unmapped neighbours, and a held result read.
    bus(1, 8'h13, 32'hDEAD);
    drive(0, 1, 0, 16'h0013, 32'h0, 2'b00, 0, 0, 0, 1, 0, 32'hDEAD);
    drive(0, 1, 1, 16'h0018, 32'h1234, 2'b00, 0, 0, 0, 1, 0, 32'h77);
    drive(0, 1, 0, 16'h001F, 32'h0, 2'b00, 0, 0, 0, 1, 0, 32'h77);
    for (int i = 0; i < 3; i++)
      drive(0, 1, 0, 16'hAB04, 32'h0, 2'b00, 0, 0, 0, 0, 32'h100 + i, 0);

    // Counter wrap with a 2-bit counter.
    bus(1, 8'h06, 32'hFFFF);
    for (int i = 0; i < 4; i++) bus(1, 8'h03, 32'h10 + i);
    bus(0, 8'h06, 32'h0);

    // Same-cycle set/clear races.
    drive(0, 1, 1, 16'h0001, 32'h7, 2'b00, 1, 0, 0, 1, 0, 0);
    bus(0, 8'h01, 32'h0);
    drive(0, 1, 1, 16'h0000, 32'h1, 2'b00, 0, 1, 0, 1, 0, 0);
    bus(0, 8'h00, 32'h0);

    // Reset while busy, colliding with bus and completion events.
    drive(1, 1, 1, 16'h0002, 32'h7, 2'b00, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) bus(0, 8'(i), 32'h0);

    for (int n = 0; n < 2000; n++) begin
      logic [7:0] a;
      int k;
      k = $urandom_range(0, 9);
      if (k <= 6)      a = 8'(k);
      else if (k == 7) a = 8'(8'h10 + $urandom_range(0, 7));
      else if (k == 8) a = 8'(8'h18 + $urandom_range(0, 7));
      else             a = 8'($urandom);
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            {8'($urandom), a}, $urandom,
            ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            $urandom, $urandom);
    end

    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
